// File: rtl/vram_row_prefetcher.sv
// Text-VRAM port owner: arbitrates the single BRAM port between the bus client and a
// character-row fetch engine that fills a double-buffered line store for the pixel decoder.
module vram_row_prefetcher #(
  parameter int WORDS_PER_ROW = 20,
  parameter int NUM_ROWS      = 30,
  parameter int ADDR_W        = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [4:0]        row,
  input  logic [4:0]        rd_word_idx,
  output logic [31:0]       rd_word,
  output logic              fetch_busy,
  output logic              fetch_done,
  output logic              line_overrun,
  input  logic              bus_req,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  input  logic [3:0]        bus_be,
  output logic              bus_ack,
  output logic [31:0]       bus_rdata,
  output logic              bus_rvalid,
  output logic              vram_en,
  output logic [3:0]        vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [31:0]       vram_wdata,
  input  logic [31:0]       vram_rdata
);

  localparam int VRAM_WORDS = NUM_ROWS * WORDS_PER_ROW;
  localparam int IDX_W      = $clog2(WORDS_PER_ROW);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  word_cnt;
  logic [ADDR_W-1:0] base;
  logic              cap_valid;
  logic [IDX_W-1:0]  cap_idx;
  logic              disp_bank;
  logic              rd_oob;
  logic [31:0]       bank [2][WORDS_PER_ROW];

  logic grant;
  logic bus_in_range;
  logic row_valid;

  assign bus_in_range = 32'(bus_addr) < VRAM_WORDS;
  assign row_valid    = 32'(row) < NUM_ROWS;
  // The fetch engine owns the port for every FETCH cycle; any other state may serve the bus.
  assign grant        = bus_req && (state != FETCH);

  always_comb begin
    bus_ack    = grant;
    vram_en    = 1'b0;
    vram_we    = '0;
    vram_addr  = '0;
    vram_wdata = '0;
    if (state == FETCH) begin
      vram_en   = 1'b1;
      vram_addr = base + ADDR_W'(word_cnt);
    end else if (grant && bus_in_range) begin
      vram_en    = 1'b1;
      vram_we    = bus_we ? bus_be : '0;
      vram_addr  = bus_addr;
      vram_wdata = bus_wdata;
    end
  end

  always_comb begin
    rd_word = '0;
    if (32'(rd_word_idx) < WORDS_PER_ROW)
      rd_word = bank[disp_bank][rd_word_idx];
  end

  assign bus_rdata = (bus_rvalid && !rd_oob) ? vram_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      word_cnt     <= '0;
      base         <= '0;
      cap_valid    <= 1'b0;
      cap_idx      <= '0;
      disp_bank    <= 1'b0;
      rd_oob       <= 1'b0;
      fetch_busy   <= 1'b0;
      fetch_done   <= 1'b0;
      line_overrun <= 1'b0;
      bus_rvalid   <= 1'b0;
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned w = 0; w < WORDS_PER_ROW; w++)
          bank[b][w] <= '0;
    end else begin
      bus_rvalid <= grant && !bus_we;
      rd_oob     <= !bus_in_range;
      fetch_done <= 1'b0;
      cap_valid  <= 1'b0;

      // BRAM data lags the issued address by one cycle, so each word lands one cycle late.
      if (cap_valid)
        bank[~disp_bank][cap_idx] <= vram_rdata;

      if (line_start && (state != IDLE))
        line_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (line_start) begin
            fetch_busy <= 1'b1;
            if (row_valid) begin
              state    <= FETCH;
              word_cnt <= '0;
              base     <= ADDR_W'(row) * ADDR_W'(WORDS_PER_ROW);
            end else begin
              state      <= DONE;
              fetch_done <= 1'b1;
              for (int unsigned w = 0; w < WORDS_PER_ROW; w++)
                bank[~disp_bank][w] <= '0;
            end
          end
        end
        FETCH: begin
          cap_valid <= 1'b1;
          cap_idx   <= word_cnt;
          word_cnt  <= word_cnt + 1'b1;
          if (word_cnt == IDX_W'(WORDS_PER_ROW - 1))
            state <= DRAIN;
        end
        DRAIN: begin
          state      <= DONE;
          fetch_done <= 1'b1;
        end
        DONE: begin
          state      <= IDLE;
          fetch_busy <= 1'b0;
          disp_bank  <= ~disp_bank;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_row_prefetcher.sv
// Self-checking bench for vram_row_prefetcher: directed fetch table, multi-cycle corner
// sequences and a randomized run against a cycle-count/transaction reference model.
module tb_vram_row_prefetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [4:0]  row;
  logic [4:0]  rd_word_idx;
  logic [31:0] rd_word;
  logic        fetch_busy, fetch_done, line_overrun;
  logic        bus_req, bus_we;
  logic [9:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        vram_en;
  logic [3:0]  vram_we;
  logic [9:0]  vram_addr;
  logic [31:0] vram_wdata;
  logic [31:0] vram_rdata = '0;

  vram_row_prefetcher #(.WORDS_PER_ROW(20), .NUM_ROWS(30), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .row(row),
    .rd_word_idx(rd_word_idx), .rd_word(rd_word), .fetch_busy(fetch_busy),
    .fetch_done(fetch_done), .line_overrun(line_overrun), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
    .vram_en(vram_en), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
  );

  always #5 clk = ~clk;

  // BRAM environment: synchronous read-first, byte-writable.
  logic [31:0] vram [600];
  always @(posedge clk) begin
    if (vram_en) begin
      vram_rdata <= vram[vram_addr];
      for (int b = 0; b < 4; b++)
        if (vram_we[b]) vram[vram_addr][8*b +: 8] <= vram_wdata[8*b +: 8];
    end
  end

  // Reference model state
  logic [31:0] model_mem [600];
  logic [31:0] disp_m [20];
  logic [31:0] snap [20];
  int          cyc = 0;
  int          t0 = 0;
  int          done_cyc = -1;
  bit          fetch_valid = 0;
  logic [9:0]  base_m = '0;
  bit          ovr_m = 0;
  bit          rv_exp = 0;
  logic [31:0] rd_exp = '0;
  bit          op_pend = 0, op_we = 0;
  logic [9:0]  op_addr = '0;
  logic [31:0] op_wd = '0;
  logic [3:0]  op_be = '0;
  int          op_wait = 0;
  int          ack_cyc = -1;
  int          last_done_obs = -1;
  int          obs_done = 0;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    done_cyc = -1;
    ovr_m    = 0;
    rv_exp   = 0;
    op_pend  = 0;
    for (int k = 0; k < 20; k++) disp_m[k] = '0;
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, then advance the model across the edge.
  task automatic tick(input bit ls, input logic [4:0] r, input logic [4:0] idx);
    bit busy_m, in_fetch, exp_ack, in_rng;
    @(negedge clk);
    line_start  = ls;
    row         = r;
    rd_word_idx = idx;
    bus_req     = op_pend;
    bus_we      = op_we;
    bus_addr    = op_addr;
    bus_wdata   = op_wd;
    bus_be      = op_be;
    #1;
    busy_m   = (done_cyc >= 0) && (cyc > t0) && (cyc <= done_cyc);
    in_fetch = busy_m && fetch_valid && (cyc <= t0 + 20);
    exp_ack  = op_pend && !in_fetch;
    in_rng   = op_addr < 10'd600;

    chk("fetch_busy", fetch_busy, busy_m);
    chk("fetch_done", fetch_done, busy_m && (cyc == done_cyc));
    chk("line_overrun", line_overrun, ovr_m);
    chk("bus_rvalid", bus_rvalid, rv_exp);
    chk("bus_rdata", bus_rdata, rv_exp ? rd_exp : 32'h0);
    chk("rd_word", rd_word, (idx < 5'd20) ? disp_m[idx] : 32'h0);
    chk("bus_ack", bus_ack, exp_ack);
    if (in_fetch)
      chk("fetch_access", {vram_en, vram_we, vram_addr}, {1'b1, 4'b0, 10'(base_m + 10'(cyc - t0 - 1))});
    else if (exp_ack && in_rng) begin
      chk("bus_access", {vram_en, vram_we, vram_addr}, {1'b1, op_we ? op_be : 4'b0, op_addr});
      if (op_we) chk("bus_wdata_pass", vram_wdata, op_wd);
    end else
      chk("vram_quiet", {vram_en, vram_we}, 5'b0);

    if (fetch_done === 1'b1) begin
      last_done_obs = cyc;
      obs_done++;
    end
    if (bus_ack === 1'b1) ack_cyc = cyc;

    rv_exp = exp_ack && !op_we;
    if (exp_ack) begin
      rd_exp = in_rng ? model_mem[op_addr] : 32'h0;
      chk("bus_wait_bound", op_wait <= 20, 1);
      if (op_we && in_rng)
        for (int b = 0; b < 4; b++)
          if (op_be[b]) model_mem[op_addr][8*b +: 8] = op_wd[8*b +: 8];
      op_pend = 0;
      op_wait = 0;
    end else if (op_pend)
      op_wait++;

    if (ls) begin
      if (busy_m) ovr_m = 1;
      else begin
        t0          = cyc;
        fetch_valid = r < 5'd30;
        done_cyc    = fetch_valid ? cyc + 22 : cyc + 1;
        base_m      = 10'(r) * 10'd20;
        for (int k = 0; k < 20; k++)
          snap[k] = fetch_valid ? model_mem[base_m + 10'(k)] : 32'h0;
      end
    end
    if (busy_m && cyc == done_cyc)
      for (int k = 0; k < 20; k++) disp_m[k] = snap[k];
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_fetch(input logic [4:0] r);
    tick(1'b1, r, 5'($urandom_range(0, 23)));
    for (int n = 0; n < 30 && cyc <= done_cyc + 1; n++)
      tick(1'b0, 5'd0, 5'($urandom_range(0, 23)));
  endtask

  task automatic peek(input logic [4:0] idx, input logic [31:0] exp, input string nm);
    #2;
    rd_word_idx = idx;
    #1;
    chk(nm, rd_word, exp);
  endtask

  task automatic set_op(input bit we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    op_pend = 1; op_we = we; op_addr = a; op_wd = d; op_be = be; op_wait = 0;
  endtask

  typedef struct {
    logic [4:0]  row;
    logic [31:0] w0;
    logic [31:0] w19;
    int          lat;
  } fvec_t;

  fvec_t tbl [5];

  initial begin
    int od;
    tbl[0] = '{5'd2,  32'hA000_0028, 32'hA000_003B, 22};
    tbl[1] = '{5'd0,  32'hA000_0000, 32'hA000_0013, 22};
    tbl[2] = '{5'd29, 32'hA000_0244, 32'hA000_0257, 22};
    tbl[3] = '{5'd31, 32'h0,         32'h0,         1};
    tbl[4] = '{5'd30, 32'h0,         32'h0,         1};

    for (int w = 0; w < 600; w++) begin
      vram[w]      = 32'hA000_0000 + 32'(w);
      model_mem[w] = 32'hA000_0000 + 32'(w);
    end
    model_reset();
    reset = 1'b1; line_start = 0; row = '0; rd_word_idx = '0;
    bus_req = 0; bus_we = 0; bus_addr = '0; bus_wdata = '0; bus_be = '0;
    #2;
    chk("rst_fetch_busy", fetch_busy, 0);
    chk("rst_fetch_done", fetch_done, 0);
    chk("rst_overrun", line_overrun, 0);
    chk("rst_rvalid", bus_rvalid, 0);
    chk("rst_ack", bus_ack, 0);
    chk("rst_vram", {vram_en, vram_we}, 5'b0);
    chk("rst_rd_word", rd_word, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Fetch table
    foreach (tbl[i]) begin
      run_fetch(tbl[i].row);
      chk("fetch_latency", 32'(last_done_obs - t0), 32'(tbl[i].lat));
      peek(5'd0, tbl[i].w0, "row_word0");
      peek(5'd19, tbl[i].w19, "row_word19");
    end

    // Bus write during FETCH waits for DRAIN; the fetched row keeps the pre-write word
    tick(1'b1, 5'd2, 5'd0);
    tick(1'b0, 5'd0, 5'd0);
    set_op(1'b1, 10'd45, 32'h1234_5678, 4'b0011);
    for (int n = 0; n < 24; n++) tick(1'b0, 5'd0, 5'd5);
    chk("wr_ack_in_drain", 32'(ack_cyc - t0), 32'd21);
    peek(5'd5, 32'hA000_002D, "row_word_unaffected");
    set_op(1'b0, 10'd45, 32'h0, 4'h0);
    tick(1'b0, 5'd0, 5'd0);
    tick(1'b0, 5'd0, 5'd0);

    // Reads at the top boundary and just past it
    set_op(1'b0, 10'd599, 32'h0, 4'h0);
    od = cyc;
    tick(1'b0, 5'd0, 5'd0);
    chk("rd599_ack_same_cycle", 32'(ack_cyc), 32'(od));
    tick(1'b0, 5'd0, 5'd0);
    set_op(1'b0, 10'd600, 32'h0, 4'h0);
    tick(1'b0, 5'd0, 5'd0);
    tick(1'b0, 5'd0, 5'd0);

    // Overrun: second line_start at FETCH cycle 5
    od = obs_done;
    tick(1'b1, 5'd3, 5'd0);
    repeat (4) tick(1'b0, 5'd0, 5'd1);
    tick(1'b1, 5'd7, 5'd1);
    repeat (24) tick(1'b0, 5'd0, 5'd19);
    chk("overrun_single_done", 32'(obs_done - od), 32'd1);
    chk("overrun_sticky", line_overrun, 1);

    // Reset asserted at FETCH cycle 10
    tick(1'b1, 5'd5, 5'd0);
    repeat (9) tick(1'b0, 5'd0, 5'd0);
    @(negedge clk);
    rd_word_idx = 5'd0;
    reset = 1'b1;
    #1;
    chk("midrst_busy", fetch_busy, 0);
    chk("midrst_vram_en", vram_en, 0);
    chk("midrst_rd_word", rd_word, 0);
    chk("midrst_done", fetch_done, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    run_fetch(5'd4);
    chk("post_rst_latency", 32'(last_done_obs - t0), 32'd22);
    peek(5'd0, model_mem[80], "post_rst_word0");

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (!op_pend && $urandom_range(0, 3) == 0)
        set_op(1'($urandom_range(0, 1)), 10'($urandom_range(0, 615)), $urandom, 4'($urandom_range(0, 15)));
      tick($urandom_range(0, 15) == 0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 23)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
